// File: rtl/led_chay_ctrl.sv
// Running-light (LED chaser) controller: rotate-left, rotate-right, bounce and fill patterns.
// Define LED_CHAY_FASTSIM_EN to shorten the step period to 16 cycles at speed 0 for simulation.
module led_chay_ctrl #(
  parameter int unsigned BASE_DIV = 12500000,
  parameter int unsigned CNT_W    = 25
) (
  input  logic       clki,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       hold,
  input  logic [1:0] mode,
  input  logic [1:0] speed,
  output logic [7:0] led,
  output logic       tick,
  output logic       wrap,
  output logic       busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  localparam logic [1:0] M_ROTL   = 2'd0;
  localparam logic [1:0] M_ROTR   = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;
  localparam logic [1:0] M_FILL   = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

`ifdef LED_CHAY_FASTSIM_EN
  localparam int unsigned EFF_DIV = 16;
`else
  localparam int unsigned EFF_DIV = BASE_DIV;
`endif

  localparam logic [CNT_W-1:0] LAST_S0 = CNT_W'(EFF_DIV - 1);
  localparam logic [CNT_W-1:0] LAST_S1 = CNT_W'((EFF_DIV >> 1) - 1);
  localparam logic [CNT_W-1:0] LAST_S2 = CNT_W'((EFF_DIV >> 2) - 1);
  localparam logic [CNT_W-1:0] LAST_S3 = CNT_W'((EFF_DIV >> 3) - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_last;
  logic             dir;
  logic [1:0]       mode_q;
  logic [1:0]       speed_q;

  logic [7:0] init_led;
  logic [7:0] nxt_led;
  logic       nxt_wrap;
  logic       nxt_dir;

  assign busy = (state != S_IDLE);

  always_comb begin
    cnt_last = LAST_S0;
    case (speed_q)
      2'd0:    cnt_last = LAST_S0;
      2'd1:    cnt_last = LAST_S1;
      2'd2:    cnt_last = LAST_S2;
      default: cnt_last = LAST_S3;
    endcase
  end

  always_comb begin
    init_led = 8'h00;
    case (mode)
      M_ROTL:   init_led = 8'h01;
      M_ROTR:   init_led = 8'h80;
      M_BOUNCE: init_led = 8'h01;
      default:  init_led = 8'h00;
    endcase
  end

  // Bounce flips dir on arrival at an end, so the next step already heads back.
  always_comb begin
    nxt_led  = led;
    nxt_wrap = 1'b0;
    nxt_dir  = dir;
    case (mode_q)
      M_ROTL: begin
        nxt_led  = {led[6:0], led[7]};
        nxt_wrap = (led == 8'h80);
      end
      M_ROTR: begin
        nxt_led  = {led[0], led[7:1]};
        nxt_wrap = (led == 8'h01);
      end
      M_BOUNCE: begin
        if (dir == DIR_LEFT) begin
          nxt_led = {led[6:0], 1'b0};
          if (led == 8'h40) nxt_dir = DIR_RIGHT;
        end else begin
          nxt_led = {1'b0, led[7:1]};
          if (led == 8'h02) begin
            nxt_dir  = DIR_LEFT;
            nxt_wrap = 1'b1;
          end
        end
      end
      default: begin
        if (led == 8'hFF) begin
          nxt_led  = 8'h00;
          nxt_wrap = 1'b1;
        end else begin
          nxt_led = {led[6:0], 1'b1};
        end
      end
    endcase
  end

  // The edge that releases hold counts as a run cycle, so a hold of N cycles delays the step by N.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      led     <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      cnt     <= '0;
      dir     <= DIR_LEFT;
      mode_q  <= '0;
      speed_q <= '0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            state   <= S_RUN;
            cnt     <= '0;
            mode_q  <= mode;
            speed_q <= speed;
            led     <= init_led;
            dir     <= DIR_LEFT;
          end
        end
        S_RUN, S_PAUSE: begin
          if (stop) begin
            state <= S_IDLE;
            led   <= '0;
            cnt   <= '0;
          end else if (hold) begin
            state <= S_PAUSE;
          end else begin
            state <= S_RUN;
            if (cnt == cnt_last) begin
              cnt     <= '0;
              tick    <= 1'b1;
              wrap    <= nxt_wrap;
              led     <= nxt_led;
              dir     <= nxt_dir;
              speed_q <= speed;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          led   <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_chay_ctrl.sv
// Directed bench for led_chay_ctrl, built with a 16-cycle base period (periods 16/8/4/2).
module tb_led_chay_ctrl;

  logic       clki;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       hold;
  logic [1:0] mode;
  logic [1:0] speed;
  logic [7:0] led;
  logic       tick;
  logic       wrap;
  logic       busy;

  int unsigned n_cmp;
  int unsigned n_err;

  led_chay_ctrl #(.BASE_DIV(16), .CNT_W(5)) dut (
    .clki  (clki),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .hold  (hold),
    .mode  (mode),
    .speed (speed),
    .led   (led),
    .tick  (tick),
    .wrap  (wrap),
    .busy  (busy)
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  task automatic cyc;
    @(posedge clki);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [1:0] s);
    mode  = m;
    speed = s;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_stop;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; hold = 1'b0; mode = 2'd0; speed = 2'd0;
    repeat (3) cyc();
    n_cmp++; if (led !== 8'h00) begin n_err++; $display("FAIL reset_led: got %h expected 00", led); end
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b expected 0", tick); end
    n_cmp++; if (wrap !== 1'b0) begin n_err++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    repeat (20) cyc();
    n_cmp++; if (busy !== 1'b0 || tick !== 1'b0) begin n_err++; $display("FAIL idle_quiet: got busy=%b tick=%b expected 0 0", busy, tick); end
  endtask

  task automatic test_rotl;
    int n;
    logic stray;
    logic [7:0] e;
    pulse_start(2'd0, 2'd0);
    n_cmp++; if (led !== 8'h01) begin n_err++; $display("FAIL rotl_init: got %h expected 01", led); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rotl_busy: got %b expected 1", busy); end
    for (int k = 1; k <= 8; k++) begin
      n = 0; stray = 1'b0;
      do begin cyc(); n++; if (wrap && !tick) stray = 1'b1; end while (!tick && n < 64);
      e = 8'h01 << (k % 8);
      n_cmp++; if (n != 16) begin n_err++; $display("FAIL rotl_period[%0d]: got %0d expected 16", k, n); end
      n_cmp++; if (led !== e) begin n_err++; $display("FAIL rotl_led[%0d]: got %h expected %h", k, led, e); end
      n_cmp++; if (wrap !== (k == 8) || stray) begin n_err++; $display("FAIL rotl_wrap[%0d]: got %b stray=%b expected %b", k, wrap, stray, k == 8); end
    end
    cyc();
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL rotl_tick_pulse: got %b expected 0", tick); end
    do_stop();
    n_cmp++; if (busy !== 1'b0 || led !== 8'h00) begin n_err++; $display("FAIL rotl_stop: got busy=%b led=%h expected 0 00", busy, led); end
  endtask

  task automatic test_rotr_mode_ignored;
    int n;
    logic [7:0] e;
    pulse_start(2'd1, 2'd3);
    mode = 2'd0;
    n_cmp++; if (led !== 8'h80) begin n_err++; $display("FAIL rotr_init: got %h expected 80", led); end
    for (int k = 1; k <= 8; k++) begin
      n = 0;
      do begin cyc(); n++; end while (!tick && n < 64);
      e = 8'h80 >> (k % 8);
      n_cmp++; if (n != 2) begin n_err++; $display("FAIL rotr_period[%0d]: got %0d expected 2", k, n); end
      n_cmp++; if (led !== e || wrap !== (k == 8)) begin n_err++; $display("FAIL rotr_step[%0d]: got led=%h wrap=%b expected %h %b", k, led, wrap, e, k == 8); end
    end
    do_stop();
  endtask

  task automatic test_bounce;
    int n;
    logic [7:0] e;
    pulse_start(2'd2, 2'd1);
    n_cmp++; if (led !== 8'h01) begin n_err++; $display("FAIL bounce_init: got %h expected 01", led); end
    for (int k = 1; k <= 14; k++) begin
      n = 0;
      do begin cyc(); n++; end while (!tick && n < 64);
      e = (k <= 7) ? (8'h01 << k) : (8'h01 << (14 - k));
      n_cmp++; if (n != 8) begin n_err++; $display("FAIL bounce_period[%0d]: got %0d expected 8", k, n); end
      n_cmp++; if (led !== e || wrap !== (k == 14)) begin n_err++; $display("FAIL bounce_step[%0d]: got led=%h wrap=%b expected %h %b", k, led, wrap, e, k == 14); end
    end
    n = 0;
    do begin cyc(); n++; end while (!tick && n < 64);
    n_cmp++; if (led !== 8'h02 || wrap !== 1'b0) begin n_err++; $display("FAIL bounce_restart: got led=%h wrap=%b expected 02 0", led, wrap); end
    do_stop();
  endtask

  task automatic test_speed_change;
    int n;
    logic [7:0] e;
    pulse_start(2'd0, 2'd0);
    repeat (5) cyc();
    speed = 2'd3;
    n = 0;
    do begin cyc(); n++; end while (!tick && n < 64);
    n_cmp++; if (n != 11) begin n_err++; $display("FAIL speed_first: got %0d expected 11", n); end
    n_cmp++; if (led !== 8'h02) begin n_err++; $display("FAIL speed_first_led: got %h expected 02", led); end
    for (int k = 2; k <= 4; k++) begin
      n = 0;
      do begin cyc(); n++; end while (!tick && n < 64);
      e = 8'h01 << k;
      n_cmp++; if (n != 2) begin n_err++; $display("FAIL speed_fast[%0d]: got %0d expected 2", k, n); end
      n_cmp++; if (led !== e) begin n_err++; $display("FAIL speed_fast_led[%0d]: got %h expected %h", k, led, e); end
    end
    do_stop();
    speed = 2'd0;
  endtask

  task automatic test_hold_and_abort;
    int n;
    logic held_ok;
    pulse_start(2'd0, 2'd0);
    repeat (5) cyc();
    hold = 1'b1;
    held_ok = 1'b1;
    repeat (5) begin
      cyc();
      if (led !== 8'h01 || tick !== 1'b0 || busy !== 1'b1) held_ok = 1'b0;
    end
    hold = 1'b0;
    n_cmp++; if (!held_ok) begin n_err++; $display("FAIL hold_frozen: got led=%h tick=%b busy=%b expected 01 0 1", led, tick, busy); end
    n = 0;
    do begin cyc(); n++; end while (!tick && n < 64);
    n_cmp++; if (n != 11) begin n_err++; $display("FAIL hold_delay: got %0d expected 11", n); end
    n_cmp++; if (led !== 8'h02) begin n_err++; $display("FAIL hold_led: got %h expected 02", led); end
    repeat (3) cyc();
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    n_cmp++; if (busy !== 1'b0 || led !== 8'h00 || tick !== 1'b0) begin n_err++; $display("FAIL startstop_run: got busy=%b led=%h tick=%b expected 0 00 0", busy, led, tick); end
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL startstop_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_fill_and_reset;
    int n;
    int ticks;
    logic [7:0] e;
    pulse_start(2'd3, 2'd2);
    n_cmp++; if (led !== 8'h00 || busy !== 1'b1) begin n_err++; $display("FAIL fill_init: got led=%h busy=%b expected 00 1", led, busy); end
    for (int k = 1; k <= 9; k++) begin
      n = 0;
      do begin cyc(); n++; end while (!tick && n < 64);
      e = (k <= 8) ? 8'((16'h0001 << k) - 16'h0001) : 8'h00;
      n_cmp++; if (n != 4) begin n_err++; $display("FAIL fill_period[%0d]: got %0d expected 4", k, n); end
      n_cmp++; if (led !== e || wrap !== (k == 9)) begin n_err++; $display("FAIL fill_step[%0d]: got led=%h wrap=%b expected %h %b", k, led, wrap, e, k == 9); end
    end
    repeat (2) cyc();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (led !== 8'h00 || busy !== 1'b0) begin n_err++; $display("FAIL reset_async: got led=%h busy=%b expected 00 0", led, busy); end
    cyc();
    rst_n = 1'b1;
    ticks = 0;
    repeat (40) begin cyc(); if (tick || busy) ticks++; end
    n_cmp++; if (ticks != 0) begin n_err++; $display("FAIL reset_no_step: got %0d active cycles expected 0", ticks); end
    pulse_start(2'd0, 2'd0);
    n = 0;
    do begin cyc(); n++; end while (!tick && n < 64);
    n_cmp++; if (n != 16 || led !== 8'h02) begin n_err++; $display("FAIL reset_restart: got n=%0d led=%h expected 16 02", n, led); end
    do_stop();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_rotl();
    test_rotr_mode_ignored();
    test_bounce();
    test_speed_change();
    test_hold_and_abort();
    test_fill_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_chay_ctrl.md
LED_CHAY_CTRL -- requirements
Module: led_chay_ctrl

Interface
REQ-001 SHALL have parameter BASE_DIV, default 12500000: step period in clki cycles at speed 0.
REQ-002 SHALL have parameter CNT_W, default 25: prescaler counter width; it SHALL hold BASE_DIV-1.
REQ-003 SHALL have port clki, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: start request, sampled each cycle.
REQ-006 SHALL have port stop, input, 1: stop request, sampled each cycle.
REQ-007 SHALL have port hold, input, 1: level; freezes the sequence while high.
REQ-008 SHALL have port mode, input, 2: pattern select; 0 = rotate left, 1 = rotate right, 2 = bounce, 3 = fill.
REQ-009 SHALL have port speed, input, 2: divider select; period = BASE_DIV >> speed.
REQ-010 SHALL have port led, output, 8: registered LED pattern.
REQ-011 SHALL have port tick, output, 1: one-cycle pulse on each pattern step.
REQ-012 SHALL have port wrap, output, 1: one-cycle pulse when the pattern completes a cycle.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and PAUSE.
REQ-015 IDLE transitions:
- start=1 and stop=0 -> RUN.
- Same edge: cnt cleared, mode_q <= mode, speed_q <= speed, led loaded with the initial pattern.
- Initial patterns: mode 0 -> 8'h01; 1 -> 8'h80; 2 -> 8'h01 with dir = left; 3 -> 8'h00.
REQ-016 RUN transitions:
- stop=1 -> IDLE.
- else hold=1 -> PAUSE.
- else cnt increments.
REQ-017 PAUSE transitions:
- stop=1 -> IDLE.
- else hold=0 -> RUN.
- cnt, led and dir frozen while in PAUSE.
REQ-018 Priority: stop beats start, hold and a due tick; with stop and start in the same cycle, the FSM SHALL end in IDLE.
REQ-019 start in RUN or PAUSE SHALL be ignored; mode changes while busy SHALL be ignored until the next start.
REQ-020 Step edge:
- In RUN with hold=0 and stop=0, on the edge where cnt == (BASE_DIV >> speed_q) - 1: cnt <= 0, tick <= 1, led <= next pattern, speed_q <= speed.
- tick and the new led SHALL become visible in the same cycle.
REQ-021 First tick SHALL occur exactly BASE_DIV >> speed_q cycles after the start edge.
- A speed change SHALL take effect only from the period following the next tick.
REQ-022 Next pattern, mode 0: rotate left (8'h80 -> 8'h01); wrap=1 on that transition.
REQ-023 Next pattern, mode 1: rotate right (8'h01 -> 8'h80); wrap=1 on that transition.
REQ-024 Next pattern, mode 2 (bounce):
- Shift in direction dir.
- At 8'h80 dir flips to right (next 8'h40); at 8'h01 dir flips to left.
- wrap=1 when led returns to 8'h01 from 8'h02.
- One full cycle = 14 ticks.
REQ-025 Next pattern, mode 3 (fill):
- led <= {led[6:0],1'b1}.
- 8'hFF -> 8'h00 with wrap=1.
REQ-026 Outputs in IDLE: led=0, tick=0, wrap=0; tick and wrap SHALL never be high outside a step edge.

Reset
REQ-027 rst_n=0 SHALL immediately force:
- state IDLE;
- led=0, tick=0, wrap=0, busy=0;
- cnt=0, dir=left, mode_q=0, speed_q=0.
REQ-028 Reset asserted mid-RUN or mid-PAUSE SHALL abort the sequence with no further tick.
REQ-029 Release SHALL require a new start before any step.

Configuration
REQ-030 Macro LED_CHAY_FASTSIM_EN SHALL, when defined, replace BASE_DIV with 16 (periods 16/8/4/2).
REQ-031 Without LED_CHAY_FASTSIM_EN, periods SHALL be BASE_DIV >> speed; all other behaviour is identical in both builds.

Verification (built with LED_CHAY_FASTSIM_EN)
REQ-032 mode=0, speed=0, start pulse -> ticks every 16 cycles with led 01,02,04,...,80,01; wrap only on 80->01.
REQ-033 mode=2, speed=1 -> led 01..80..01 over 14 ticks spaced 8 cycles; wrap on the 14th tick only.
REQ-034 speed 0->3 changed 5 cycles into a period -> that tick at cycle 16; following ticks every 2 cycles.
REQ-035 hold high 5 cycles mid-period -> tick delayed exactly 5 cycles, led unchanged while held; start+stop same cycle while RUN -> IDLE, led=0.
REQ-036 mode=3 -> led 00,01,03,07,...,FF,00 with wrap at FF->00; rst_n pulsed low mid-RUN -> led=0, busy=0 at once, no tick until next start.
